// File: rtl/data_bus_bridge_pkg.sv
// Shared constants for the data-side bridge: MMIO addresses, STATUS layout, decode select.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: address constants, STATUS bit indices, sel_e decode enum, addr_hit() helper.
package dbus_pkg;

   localparam logic [31:0] ADDR_TX_DATA = 32'hFFFF_0000;
   localparam logic [31:0] ADDR_STATUS  = 32'hFFFF_0004;
   localparam logic [31:0] ADDR_CYCLES  = 32'hFFFF_0008;
   localparam logic [31:0] ADDR_DONE    = 32'hFFFF_000C;

   // STATUS register layout: {0.., ovf, full, empty, count[6:0]}
   localparam int ST_OVF   = 9;
   localparam int ST_FULL  = 8;
   localparam int ST_EMPTY = 7;
   localparam int ST_CNT_W = 7;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_TX,
      SEL_STATUS,
      SEL_CYCLES,
      SEL_DONE
   } sel_e;

   // Word-granular match: the two byte-offset bits never take part in decode.
   function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:2] == base[31:2];
   endfunction

endpackage

// File: rtl/data_bus_bridge_if.sv
// Core RAM port plus outbound byte stream and done flag, bundled for the bridge.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready handshake on the byte stream; core side has none.
// Modports: slave = bridge side, master = core/sink side.
interface data_bus_bridge_if #(
   parameter int WIDTH = 32
);
   logic             writeram;
   logic [WIDTH-1:0] ramaddress;
   logic [WIDTH-1:0] writeramdata;
   logic [WIDTH-1:0] readramdata;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             done;

   modport slave (
      input  writeram, ramaddress, writeramdata, tx_ready,
      output readramdata, tx_data, tx_valid, done
   );

   modport master (
      output writeram, ramaddress, writeramdata, tx_ready,
      input  readramdata, tx_data, tx_valid, done
   );
endinterface

// File: rtl/data_bus_bridge_stream_fifo.sv
// Byte FIFO whose output is a registered head byte (stable while valid && !ready).
// Latency: a byte pushed into an empty FIFO is on head_dat/head_vld the cycle after the push edge.
// Backpressure: pop only on head_vld && pop_rdy; push when full is dropped and flagged via push_drop.
// Ports: clk, nrst (async active-low); push/push_dat in; pop_rdy in;
//        head_dat/head_vld out; full/empty/count status out; push_drop out (combinational).
module stream_fifo #(
   parameter  int DEPTH = 16,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          pop_rdy,
   output logic [7:0]    head_dat,
   output logic          head_vld,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          push_drop
);

   logic [7:0]    fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    head_q, head_d;
   logic          push_ok;
   logic          pop_ok;

   always_comb begin
      full      = (cnt_q == CW'(DEPTH));
      empty     = (cnt_q == '0);
      pop_ok    = !empty && pop_rdy;
      // No full-bypass: a push at full is dropped even if a pop frees a slot this cycle.
      push_ok   = push && !full;
      push_drop = push && full;

      wr_ptr_d  = wr_ptr_q + PW'(push_ok);
      rd_ptr_d  = rd_ptr_q + PW'(pop_ok);
      cnt_d     = cnt_q + CW'(push_ok) - CW'(pop_ok);

      // The head register holds what will sit at rd_ptr after this edge. The slot at
      // rd_ptr+1 is only valid in memory if it was written before this cycle, so the
      // cases where the new head is the byte being pushed right now take push_dat.
      head_d = head_q;
      if (empty) begin
         if (push_ok) head_d = push_dat;
      end else if (pop_ok) begin
         if (cnt_q == CW'(1)) begin
            if (push_ok) head_d = push_dat;
         end else begin
            head_d = fifo_mem[rd_ptr_q + PW'(1)];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

   // Storage is not reset; stale bytes are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= push_dat;
   end

   assign head_dat = head_q;
   assign head_vld = !empty;
   assign count    = cnt_q;

endmodule

// File: rtl/data_bus_bridge.sv
// Data-side bridge behind the core RAM port: word RAM plus MMIO (TX byte FIFO, STATUS, CYCLES, DONE).
// Latency: readramdata is registered, one cycle after the address; stores land at the writeram edge.
// Backpressure: none toward the core; TX stream uses valid/ready and drops pushes at full (sticky ovf).
// Ports: clk, nrst (async active-low); bus (slave modport): writeram, ramaddress, writeramdata,
//        readramdata, tx_data, tx_valid, tx_ready, done. WIDTH must be 32 to match the MMIO map.
module data_bus_bridge
   import dbus_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RAM_AW     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input logic               clk,
   input logic               nrst,
   data_bus_bridge_if.slave  bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // Behavioural array so the FPGA tool can map it to block RAM.
   logic [WIDTH-1:0]  ram [2**RAM_AW];

   sel_e              sel;
   logic [RAM_AW-1:0] word_idx;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_cnt;
   logic              fifo_drop;
   logic [7:0]        fifo_head;
   logic              fifo_vld;
   logic [WIDTH-1:0]  status_w;

   logic [WIDTH-1:0]  rdata_q, rdata_d;
   logic [WIDTH-1:0]  cycles_q, cycles_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic              unused_addr_lo;
   assign unused_addr_lo = ^bus.ramaddress[1:0];

   // Address decode; RAM occupies the bottom 4*2**RAM_AW bytes with no aliasing above it.
   always_comb begin
      sel      = SEL_NONE;
      word_idx = bus.ramaddress[RAM_AW+1:2];
      if (bus.ramaddress[WIDTH-1:RAM_AW+2] == '0)      sel = SEL_RAM;
      else if (addr_hit(bus.ramaddress, ADDR_TX_DATA)) sel = SEL_TX;
      else if (addr_hit(bus.ramaddress, ADDR_STATUS))  sel = SEL_STATUS;
      else if (addr_hit(bus.ramaddress, ADDR_CYCLES))  sel = SEL_CYCLES;
      else if (addr_hit(bus.ramaddress, ADDR_DONE))    sel = SEL_DONE;
   end

   assign fifo_push = bus.writeram && (sel == SEL_TX);

   stream_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (fifo_push),
      .push_dat  (bus.writeramdata[7:0]),
      .pop_rdy   (bus.tx_ready),
      .head_dat  (fifo_head),
      .head_vld  (fifo_vld),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_cnt),
      .push_drop (fifo_drop)
   );

   always_comb begin
      status_w                 = '0;
      status_w[ST_OVF]         = ovf_q;
      status_w[ST_FULL]        = fifo_full;
      status_w[ST_EMPTY]       = fifo_empty;
      status_w[ST_CNT_W-1:0]   = ST_CNT_W'(fifo_cnt);
   end

   always_comb begin
      cycles_d = cycles_q + WIDTH'(1);

      done_d = done_q;
      if (bus.writeram && (sel == SEL_DONE)) done_d = bus.writeramdata[0];

      // Overflow and clear come from different addresses, so they never coincide.
      ovf_d = ovf_q;
      if (fifo_drop)                               ovf_d = 1'b1;
      else if (bus.writeram && (sel == SEL_STATUS)) ovf_d = 1'b0;

      // Read mux samples pre-edge state: RAM gives old data on read-during-write,
      // CYCLES gives the value before this edge's increment.
      rdata_d = '0;
      unique case (sel)
         SEL_RAM:    rdata_d = ram[word_idx];
         SEL_STATUS: rdata_d = status_w;
         SEL_CYCLES: rdata_d = cycles_q;
         SEL_DONE:   rdata_d = WIDTH'(done_q);
         default:    rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rdata_q  <= '0;
         cycles_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         cycles_q <= cycles_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (bus.writeram && (sel == SEL_RAM)) ram[word_idx] <= bus.writeramdata;
   end

   assign bus.readramdata = rdata_q;
   assign bus.tx_data     = fifo_head;
   assign bus.tx_valid    = fifo_vld;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;
   import dbus_pkg::*;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   data_bus_bridge_if #(.WIDTH(32)) bus ();

   data_bus_bridge #(
      .WIDTH      (32),
      .RAM_AW     (12),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb_q [$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Store: an accepted TX byte is queued as expected stream output.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.writeram     = 1'b1;
      bus.ramaddress   = a;
      bus.writeramdata = d;
      if (a == ADDR_TX_DATA && sb_q.size() < DEPTH) sb_q.push_back(d[7:0]);
      tick();
      bus.writeram = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.writeram   = 1'b0;
      bus.ramaddress = a;
      tick();
      check_val(tag, bus.readramdata, exp);
   endtask

   task automatic drain(input string tag);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH + 4 && bus.tx_valid; i++) tick();
      check_val({tag, "_idle"}, 32'(bus.tx_valid), 32'd0);
      check_val({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
      bus.tx_ready = 1'b0;
   endtask

   // Stream monitor: inputs are stable mid-cycle, so a handshake seen at the
   // falling edge is the one the next rising edge will take.
   always @(negedge clk) begin
      if (nrst === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
         check_val("tx_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) check_val("tx_byte", 32'(bus.tx_data), 32'(sb_q.pop_front()));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] cyc_a;

   initial begin
      nrst             = 1'b0;
      bus.writeram     = 1'b0;
      bus.ramaddress   = '0;
      bus.writeramdata = '0;
      bus.tx_ready     = 1'b0;
      repeat (3) tick();
      check_val("rst_rdata",  bus.readramdata, 32'd0);
      check_val("rst_valid",  32'(bus.tx_valid), 32'd0);
      check_val("rst_txdata", 32'(bus.tx_data), 32'd0);
      check_val("rst_done",   32'(bus.done), 32'd0);

      bus.ramaddress = ADDR_CYCLES;
      nrst = 1'b1;
      tick();
      check_val("cycles_first", bus.readramdata, 32'd0);
      rd("cycles_second", ADDR_CYCLES, 32'd1);
      rd("rst_status", ADDR_STATUS, 32'h80);

      // RAM
      wr(32'h10, 32'hDEAD_BEEF);
      rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
      wr(32'h10, 32'hCAFE_F00D);
      check_val("ram_rdw_old", bus.readramdata, 32'hDEAD_BEEF);
      rd("ram_new", 32'h10, 32'hCAFE_F00D);
      wr(32'h14, 32'h1234_5678);
      rd("ram_lo_bits", 32'h13, 32'hCAFE_F00D);
      rd("ram_neighbor", 32'h14, 32'h1234_5678);
      wr(32'h0, 32'h0101_0101);
      wr(32'h3FFC, 32'hA5A5_5A5A);
      wr(32'h4000, 32'hBADB_AD00);
      rd("ram_top", 32'h3FFC, 32'hA5A5_5A5A);
      rd("ram_beyond", 32'h4000, 32'd0);
      rd("ram_no_alias", 32'h0, 32'h0101_0101);

      // Streaming with sink always ready
      bus.tx_ready = 1'b1;
      wr(ADDR_TX_DATA, 32'h11);
      check_val("stream_v0", 32'(bus.tx_valid), 32'd1);
      check_val("stream_d0", 32'(bus.tx_data), 32'h11);
      wr(ADDR_TX_DATA, 32'h22);
      check_val("stream_d1", 32'(bus.tx_data), 32'h22);
      wr(ADDR_TX_DATA, 32'h33);
      check_val("stream_d2", 32'(bus.tx_data), 32'h33);
      tick();
      check_val("stream_end", 32'(bus.tx_valid), 32'd0);
      bus.tx_ready = 1'b0;
      rd("stream_status", ADDR_STATUS, 32'h80);

      // Overflow: 17 pushes into 16 slots
      for (int i = 0; i < DEPTH + 1; i++) wr(ADDR_TX_DATA, 32'hA0 + 32'(i));
      rd("ovf_status", ADDR_STATUS, 32'h310);
      drain("ovf_drain");
      rd("ovf_sticky", ADDR_STATUS, 32'h280);
      wr(ADDR_STATUS, 32'h0001_2345);
      rd("ovf_cleared", ADDR_STATUS, 32'h80);

      // Simultaneous push/pop at count 5
      for (int i = 0; i < 5; i++) wr(ADDR_TX_DATA, 32'h50 + 32'(i));
      rd("pp_pre", ADDR_STATUS, 32'h05);
      bus.tx_ready = 1'b1;
      wr(ADDR_TX_DATA, 32'h55);
      bus.tx_ready = 1'b0;
      rd("pp_count", ADDR_STATUS, 32'h05);
      drain("pp_drain");

      // Push at full with a pop: pop happens, push dropped, ovf set
      for (int i = 0; i < DEPTH; i++) wr(ADDR_TX_DATA, 32'hC0 + 32'(i));
      rd("full_pre", ADDR_STATUS, 32'h110);
      bus.tx_ready = 1'b1;
      wr(ADDR_TX_DATA, 32'hEE);
      bus.tx_ready = 1'b0;
      rd("full_pushpop", ADDR_STATUS, 32'h20F);
      drain("full_drain");
      wr(ADDR_STATUS, 32'd0);
      rd("full_clear", ADDR_STATUS, 32'h80);

      // CYCLES spacing
      bus.ramaddress = ADDR_CYCLES;
      tick();
      cyc_a = bus.readramdata;
      repeat (10) tick();
      check_val("cycles_delta", bus.readramdata - cyc_a, 32'd10);

      // DONE and unmapped
      wr(ADDR_DONE, 32'd1);
      check_val("done_set", 32'(bus.done), 32'd1);
      rd("done_read", ADDR_DONE, 32'd1);
      wr(ADDR_DONE, 32'hFFFF_FFFE);
      check_val("done_clr", 32'(bus.done), 32'd0);
      rd("unmapped", 32'h8000_0000, 32'd0);
      rd("txdata_read", ADDR_TX_DATA, 32'd0);

      // Reset in the middle of a stream
      wr(ADDR_DONE, 32'd1);
      for (int i = 0; i < 7; i++) wr(ADDR_TX_DATA, 32'h70 + 32'(i));
      rd("mid_pre", ADDR_STATUS, 32'h07);
      nrst = 1'b0;
      #1;
      check_val("mid_valid",  32'(bus.tx_valid), 32'd0);
      check_val("mid_txdata", 32'(bus.tx_data), 32'd0);
      check_val("mid_done",   32'(bus.done), 32'd0);
      check_val("mid_rdata",  bus.readramdata, 32'd0);
      sb_q.delete();
      bus.ramaddress = ADDR_CYCLES;
      tick();
      nrst = 1'b1;
      tick();
      check_val("mid_cycles", bus.readramdata, 32'd0);
      rd("mid_status", ADDR_STATUS, 32'h80);
      rd("mid_ram_keep", 32'h10, 32'hCAFE_F00D);

      check_val("sb_final", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
